// File: rtl/rtype_issue_unit_pkg.sv
// Shared types and encoding constants for the R-type issue unit.
package rtype_issue_unit_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // RISC-V R-type major opcode
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    // funct7 values accepted by the downstream datapath (base and alternate, e.g. add/sub)
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/rtype_word_check.sv
// Combinational classifier: splits a program word into terminator, legal R-type
// or illegal. Exactly one of the three outputs is high for any input.
module rtype_word_check
    import rtype_issue_unit_pkg::*;
(
    input  logic [31:0] word_i,
    output logic        is_term_o,
    output logic        is_legal_o,
    output logic        is_illegal_o
);

    logic opc_ok;
    logic f7_ok;

    assign opc_ok = (word_i[6:0] == OPC_RTYPE);
    assign f7_ok  = (word_i[31:25] == F7_BASE) || (word_i[31:25] == F7_ALT);

    // An all-zero word terminates the program; it can never be a legal R-type
    // because its opcode field is zero.
    always_comb begin
        is_term_o    = (word_i == 32'h0);
        is_legal_o   = opc_ok && f7_ok;
        is_illegal_o = !is_term_o && !is_legal_o;
    end

endmodule

// File: rtl/rtype_issue_unit.sv
// Program-store sequencer that presents R-type instructions to a downstream
// datapath with a valid/ready handshake, stopping on a zero word or an illegal one.
module rtype_issue_unit
    import rtype_issue_unit_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic          start,
    input  logic          ready,
    output logic [31:0]   I,
    output logic          valid,
    output logic [AW-1:0] pc,
    output logic [AW:0]   issued_cnt,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   store_q [DEPTH];
    logic [31:0]   word;
    logic          w_term, w_legal, w_illegal;

    assign word = store_q[pc_q];

    rtype_word_check u_check (
        .word_i       (word),
        .is_term_o    (w_term),
        .is_legal_o   (w_legal),
        .is_illegal_o (w_illegal)
    );

    // Program store: writable only while not issuing; reset leaves contents alone
    always_ff @(posedge clk) begin
        if (!rst && prog_we && (state_q != ST_RUN)) begin
            store_q[prog_addr] <= prog_data;
        end
    end

    // State, pc and accepted-instruction counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: walk the store while words are legal and accepted
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (w_illegal) begin
                    // pc stays on the offending word for inspection
                    state_d = ST_ERR;
                end else if (w_term) begin
                    state_d = ST_DONE;
                end else if (ready) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (pc_q < PC_LAST) begin
                        pc_d = pc_q + 1'b1;
                    end else begin
                        // last entry accepted: stop rather than wrap to 0
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Outputs: handshake, presented word and state flags
    always_comb begin
        valid      = (state_q == ST_RUN) && w_legal;
        I          = valid ? word : 32'h0;
        pc         = pc_q;
        issued_cnt = cnt_q;
        busy       = (state_q == ST_RUN);
        done       = (state_q == ST_DONE);
        err        = (state_q == ST_ERR);
    end

endmodule

// File: tb/tb_rtype_issue_unit.sv
// Directed self-checking bench for rtype_issue_unit.
module tb_rtype_issue_unit;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [31:0] prog_data;
    logic        start;
    logic        ready;
    logic [31:0] I;
    logic        valid;
    logic [4:0]  pc;
    logic [5:0]  issued_cnt;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int errors;

    localparam logic [31:0] W_ADD  = 32'h006283B3;
    localparam logic [31:0] W_SUB  = 32'h406283B3;
    localparam logic [31:0] W_ADDI = 32'h00000013;
    localparam logic [31:0] W_NEW  = 32'h40A383B3;

    rtype_issue_unit #(.DEPTH(32), .AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .ready      (ready),
        .I          (I),
        .valid      (valid),
        .pc         (pc),
        .issued_cnt (issued_cnt),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [4:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // distinct legal word per address: rd = index, funct7 alternates add/sub
    function automatic logic [31:0] fill_word(input int i);
        logic [4:0] rd;
        rd = i[4:0];
        return {(i % 2 == 1) ? 7'b0100000 : 7'b0000000, 5'd6, 5'd5, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; ready = 1'b1;
        tick(); tick();
        rst = 1'b0; start = 1'b0; ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
        checks++; if (I !== 32'h0) begin errors++; $display("FAIL reset_I got %h want 00000000", I); end
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", pc); end
        checks++; if (issued_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", issued_cnt); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, err}); end
        $display("reset: idle state checked");
    endtask

    task automatic test_single();
        load_word(5'd0, W_ADD);
        load_word(5'd1, 32'h0);
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (valid !== 1'b1 || I !== W_ADD) begin errors++; $display("FAIL single_issue got v=%0b I=%h want v=1 I=%h", valid, I, W_ADD); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b want 1", busy); end
        tick();
        checks++; if (valid !== 1'b0 || I !== 32'h0) begin errors++; $display("FAIL single_term got v=%0b I=%h want v=0 I=0", valid, I); end
        tick();
        checks++; if (done !== 1'b1 || issued_cnt !== 6'd1 || pc !== 5'd1) begin errors++; $display("FAIL single_done got done=%0b cnt=%0d pc=%0d want 1 1 1", done, issued_cnt, pc); end
        ready = 1'b0;
        $display("single: add issued once");
    endtask

    task automatic test_stall();
        load_word(5'd0, W_SUB);
        start = 1'b1; ready = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (valid !== 1'b1 || I !== W_SUB || pc !== 5'd0) begin errors++; $display("FAIL stall_hold%0d got v=%0b I=%h pc=%0d want 1 %h 0", k, valid, I, pc, W_SUB); end
            tick();
        end
        ready = 1'b1;
        checks++; if (valid !== 1'b1 || I !== W_SUB || pc !== 5'd0 || issued_cnt !== 6'd0) begin errors++; $display("FAIL stall_4th got v=%0b I=%h pc=%0d cnt=%0d", valid, I, pc, issued_cnt); end
        tick();
        checks++; if (issued_cnt !== 6'd1 || pc !== 5'd1) begin errors++; $display("FAIL stall_accept got cnt=%0d pc=%0d want 1 1", issued_cnt, pc); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %0b want 1", done); end
        ready = 1'b0;
        $display("stall: sub held 3 cycles then accepted");
    endtask

    task automatic test_illegal();
        load_word(5'd0, W_ADD);
        load_word(5'd1, W_SUB);
        load_word(5'd2, W_ADDI);
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (I !== W_ADD || pc !== 5'd0) begin errors++; $display("FAIL ill_first got I=%h pc=%0d", I, pc); end
        tick();
        checks++; if (I !== W_SUB || pc !== 5'd1) begin errors++; $display("FAIL ill_second got I=%h pc=%0d", I, pc); end
        tick();
        checks++; if (valid !== 1'b0 || I !== 32'h0 || pc !== 5'd2) begin errors++; $display("FAIL ill_block got v=%0b I=%h pc=%0d", valid, I, pc); end
        tick();
        checks++; if (err !== 1'b1 || pc !== 5'd2 || issued_cnt !== 6'd2 || valid !== 1'b0) begin errors++; $display("FAIL ill_err got err=%0b pc=%0d cnt=%0d v=%0b", err, pc, issued_cnt, valid); end
        // ready without valid must not disturb anything
        tick(); tick();
        checks++; if (err !== 1'b1 || pc !== 5'd2 || issued_cnt !== 6'd2) begin errors++; $display("FAIL ill_ready_idle got err=%0b pc=%0d cnt=%0d", err, pc, issued_cnt); end
        ready = 1'b0;
        $display("illegal: addi stopped issue at pc 2");
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) load_word(i[4:0], fill_word(i));
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++; if (valid !== 1'b1 || I !== fill_word(i) || pc !== i[4:0]) begin errors++; $display("FAIL fill_%0d got v=%0b I=%h pc=%0d want I=%h", i, valid, I, pc, fill_word(i)); end
            start = (i == 10);  // start while running must be ignored
            tick();
            start = 1'b0;
        end
        checks++; if (done !== 1'b1 || issued_cnt !== 6'd32 || pc !== 5'd31 || valid !== 1'b0) begin errors++; $display("FAIL fill_end got done=%0b cnt=%0d pc=%0d v=%0b", done, issued_cnt, pc, valid); end
        ready = 1'b0;
        $display("fill: 32 words issued");
    endtask

    task automatic test_rst_mid();
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++; if (issued_cnt !== 6'd3 || pc !== 5'd3) begin errors++; $display("FAIL rstmid_pre got cnt=%0d pc=%0d want 3 3", issued_cnt, pc); end
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; ready = 1'b0;
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || I !== 32'h0 || pc !== 5'd0 || issued_cnt !== 6'd0) begin errors++; $display("FAIL rstmid_idle got busy=%0b v=%0b pc=%0d cnt=%0d", busy, valid, pc, issued_cnt); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (valid !== 1'b1 || I !== fill_word(0) || pc !== 5'd0 || issued_cnt !== 6'd0) begin errors++; $display("FAIL rstmid_restart got v=%0b I=%h pc=%0d", valid, I, pc); end
        $display("rst_mid: aborted and restarted from 0");
    endtask

    task automatic test_run_write();
        // still in RUN at pc 0: the write must be dropped
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = W_NEW; ready = 1'b1;
        tick();
        prog_we = 1'b0;
        for (int i = 0; i < 31; i++) tick();
        checks++; if (done !== 1'b1 || issued_cnt !== 6'd32) begin errors++; $display("FAIL rw_done got done=%0b cnt=%0d", done, issued_cnt); end
        ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (I !== fill_word(0)) begin errors++; $display("FAIL rw_unchanged got %h want %h", I, fill_word(0)); end
        ready = 1'b1;
        for (int i = 0; i < 32; i++) tick();
        ready = 1'b0;
        // write and start in the same cycle from DONE
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = W_NEW; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        checks++; if (valid !== 1'b1 || I !== W_NEW || pc !== 5'd0) begin errors++; $display("FAIL rw_new got v=%0b I=%h pc=%0d want I=%h", valid, I, pc, W_NEW); end
        $display("run_write: RUN write ignored, later write seen");
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; ready = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_illegal();
        test_fill();
        test_rst_mid();
        test_run_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtype_issue_unit.md
RTYPE_ISSUE_UNIT -- requirements
Module: rtype_issue_unit

Interface
REQ-001 Parameters: DEPTH, default 32, program-store entries; AW, default 5, address width (clog2 of DEPTH).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 prog_we  input  1  write strobe into the program store.
REQ-005 prog_addr  input  AW  program-store write address.
REQ-006 prog_data  input  32  instruction word to write.
REQ-007 start  input  1  one-cycle pulse that begins issue from address 0.
REQ-008 ready  input  1  downstream R-type datapath accepts the presented instruction this cycle.
REQ-009 I  output  32  instruction presented to the datapath (RISC-V R-type encoding).
REQ-010 valid  output  1  I holds a legal R-type word awaiting acceptance.
REQ-011 pc  output  AW  address of the word currently presented.
REQ-012 issued_cnt  output  AW+1  number of instructions accepted since the last start.
REQ-013 busy, done, err  output  1 each  state flags, RUN / DONE / ERR respectively.

Function
REQ-014 Program store: DEPTH x 32 register array with a synchronous write when prog_we=1 and state is IDLE, DONE or ERR; combinational read at pc.
REQ-015 prog_we while in RUN shall be ignored, with no write.
REQ-016 FSM states: IDLE, RUN, DONE, ERR; state changes only on the clock edge.
REQ-017 IDLE->RUN, DONE->RUN and ERR->RUN on start=1; each such transition shall set pc=0 and issued_cnt=0.
REQ-018 start while in RUN shall be ignored.
REQ-019 Word classification in RUN, for W = store[pc]:
- TERM if W == 32'h0.
- LEGAL if W[6:0] == 7'b0110011 and W[31:25] is 7'b0000000 or 7'b0100000.
- ILLEGAL otherwise.
REQ-020 In RUN with a LEGAL word: valid=1 and I=W.
REQ-021 When valid=1 and ready=1: issued_cnt increments, and pc increments if pc < DEPTH-1; else next state is DONE.
REQ-022 When valid=1 and ready=0: pc, I and valid shall hold unchanged for as many cycles as ready stays low.
REQ-023 TERM word in RUN: valid=0 and next state is DONE; pc holds.
REQ-024 ILLEGAL word in RUN: valid=0 and next state is ERR; pc holds, pointing at the offending word.
REQ-025 Latency: first valid=1 is on the cycle after the start edge; issue rate is one instruction per cycle while ready=1.
REQ-026 I shall be 32'h0 whenever valid=0.
REQ-027 In all states other than RUN, valid=0.
REQ-028 busy, done and err decode the state directly: busy=1 only in RUN, done=1 only in DONE, err=1 only in ERR.
REQ-029 ready with valid=0 shall have no effect on any state.
REQ-030 Simultaneous start and prog_we in IDLE: the write completes, and the RUN read at address 0 sees the newly written word if prog_addr=0.

Reset
REQ-031 rst=1 at a clock edge shall set state=IDLE, pc=0, issued_cnt=0 and valid=0, so I=0 and busy=done=err=0.
REQ-032 rst has priority over start, ready and prog_we in the same cycle.
REQ-033 rst mid-RUN shall abort issue immediately, with no further acceptance counted.
REQ-034 Program-store contents are not altered by rst.

Structure
REQ-035 A shared package shall hold:
- the state enumeration (IDLE, RUN, DONE, ERR);
- the R-type opcode 7'b0110011;
- the legal funct7 constants 7'b0000000 and 7'b0100000.
REQ-036 One sub-module, rtype_word_check, shall classify a 32-bit word as TERM, LEGAL or ILLEGAL combinationally.
REQ-037 The FSM, pc, counter and program store shall live in rtype_issue_unit.

Verification
REQ-038 Load add x7,x5,x6 (32'h006283B3) at address 0 and 0 at address 1, start, ready=1 -> valid=1 with I=32'h006283B3 for exactly 1 cycle, then done=1, issued_cnt=1, pc=1.
REQ-039 Load sub 32'h406283B3 at address 0, start, hold ready=0 for 3 cycles then 1 -> I stable for 4 cycles, pc stays 0 until acceptance, then issued_cnt=1.
REQ-040 Load 32'h00000013 (addi) at address 2 behind two legal words, start, ready=1 -> 2 issues, then err=1 with pc=2 and valid=0.
REQ-041 Fill all 32 entries with legal words, ready=1 -> 32 issues, issued_cnt=32, done=1, pc=31, no wrap to 0.
REQ-042 Assert rst after 3 accepted issues -> next cycle state IDLE, valid=0, pc=0, issued_cnt=0; a new start reissues the same store contents from address 0.
REQ-043 Drive prog_we to address 0 during RUN -> store unchanged; after DONE, the rewritten word is presented on the next start.
